meas_filter: RTL and testbench
==============================

// Module: meas_filter
// PURPOSE
//  Downstream consumer of the I2C ranging front-end's 16-bit data/done output.
//  Captures each completed measurement and keeps a 2^LOG2_N-deep moving average.
//  Drives a hysteretic presence flag for the door controller.
//  Sits on the fast system clock, beside the measurement front-end, feeding door control logic.
// PARAMETERS
//  DW          16      measurement width, bits
//  LOG2_N      3       log2 of averaging window (N=8)
//  TH_NEAR     16'd400 avg <= TH_NEAR sets present_o
//  TH_FAR      16'd600 avg >= TH_FAR clears present_o; must satisfy TH_NEAR < TH_FAR
//  TIMEOUT_CYC 24'd5_000_000  cycles without a sample before fault (only with MEAS_FILTER_TIMEOUT_EN)
// PORTS
//  clk        in   1       system clock
//  resetG     in   1       async active-low reset
//  data_i     in   DW      measurement from front-end, valid when done_i rises
//  done_i     in   1       front-end done level; a rising edge marks a new sample
//  flush_i    in   1       sync clear of window, sum and state
//  avg_o      out  DW      moving average, registered
//  avg_stb_o  out  1       1-cycle pulse when avg_o updates in RUN
//  present_o  out  1       hysteretic presence flag
//  fill_o     out  LOG2_N+1  samples held in window (saturates at N)
//  fault_o    out  1       no-sample timeout (tied 0 without the macro)
// BEHAVIOUR
//  - Reset (resetG=0, async): all outputs 0, sum=0, buffer entries=0, wr_ptr=0, state=FILL.
//  - Edge detect: done_q registers done_i; edge = done_i & ~done_q.
//    done_i must be low >=1 cycle between samples. A held-high done_i is one sample.
//  - Cycle t edge: data_i latched into samp_q; wr_ptr entry read as old_q.
//  - Cycle t+1: buf[wr_ptr]<=samp_q; sum<=sum+samp_q-old_q; wr_ptr++ (wraps N-1->0); fill_o++ until N.
//  - Cycle t+2: avg_o<=sum[DW+LOG2_N-1:LOG2_N]; avg_stb_o=1 only if state==RUN. Latency edge->avg = 2 clk.
//  - sum width DW+LOG2_N. Never overflows. Entries are 0 during FILL, so subtraction never underflows.
//  - FSM: FILL -> RUN when the Nth sample is written (fill_o reaches N). RUN -> FILL only on flush_i or reset.
//    In FILL, avg_o still tracks sum>>LOG2_N, avg_stb_o stays 0 and present_o holds.
//  - Hysteresis, evaluated on the avg_stb_o cycle using the new avg:
//    avg<=TH_NEAR -> present_o=1; avg>=TH_FAR -> present_o=0; otherwise hold.
//    present_o updates 1 cycle after avg_stb_o.
//  - flush_i=1: next cycle sum=0, entries=0, wr_ptr=0, fill_o=0, state=FILL, avg_o=0, present_o=0.
//    Any sample in flight is dropped. flush_i wins over a simultaneous edge.
//  - Back-to-back edges every 2 cycles are supported. The pipeline never stalls.
//  - Reset mid-pipeline discards all in-flight data.
// CONFIGURATION
//  MEAS_FILTER_TIMEOUT_EN defined:
//    - 24-bit counter clears on every edge and on flush_i, increments otherwise, saturates.
//    - fault_o=1 when counter==TIMEOUT_CYC; fault_o clears on the next edge or flush.
//  Undefined: no counter; fault_o=0 constant.
// STRUCTURE
//  Shared package/header meas_pkg.vh: `define for DW, LOG2_N, state encodings FILL=1'b0 and RUN=1'b1,
//  and the default thresholds, so the door controller uses the same values.
//  One sub-module, meas_ring:
//    - N x DW buffer with sync write, read-before-write old-entry output, pointer and clear.
//  meas_filter owns edge detect, sum, FSM, hysteresis and timeout.
// TESTING
//  1 Reset, then 8 samples of 16'd800 spaced 50 cycles:
//    avg_stb_o only on the 8th, avg_o=800, present_o=0, fill_o=8.
//  2 After 1, 8 samples of 16'd200:
//    avg steps 725,650,...,200; present_o rises on first avg<=400 (avg=350, 6th), stays 1.
//  3 From present_o=1, samples of 500:
//    avg converges to 500; present_o holds 1 (between thresholds). Then samples of 700: clears when avg>=600.
//  4 Window full, sample 16'hFFFF x8:
//    avg_o=16'hFFFF, no overflow. Then flush_i coincident with an edge: sample dropped, fill_o=0, avg_o=0.
//  5 done_i held high 100 cycles, then edges 2 cycles apart:
//    exactly one sample per rising edge; avg_stb_o 2 cycles after each edge.
//  6 With MEAS_FILTER_TIMEOUT_EN, TIMEOUT_CYC=1000, no edges:
//    fault_o=1 at cycle 1000, clears on the next edge. Without the macro, fault_o stays 0.

Source files
------------

// File: rtl/meas_filter_pkg.sv
// Shared constants and state encoding for the measurement filter and the door controller.
// Default window size, thresholds and timeout live here so both sides agree.
package meas_filter_pkg;

    localparam int unsigned DW_DEF      = 16;
    localparam int unsigned LOG2_N_DEF  = 3;
    localparam int unsigned TH_NEAR_DEF = 400;
    localparam int unsigned TH_FAR_DEF  = 600;
    localparam int unsigned TIMEOUT_DEF = 5_000_000;
    localparam int unsigned TMO_W       = 24;

    typedef enum logic {
        StFill = 1'b0,
        StRun  = 1'b1
    } meas_state_e;

endpackage

// File: rtl/meas_filter_ring.sv
// N-entry sample ring: synchronous write at the write pointer, combinational read of the
// entry about to be overwritten, and a synchronous clear of all entries and the pointer.
module meas_filter_ring #(
    parameter int unsigned DW     = 16,
    parameter int unsigned LOG2_N = 3
) (
    input  logic          clk,
    input  logic          resetG,
    input  logic          clr_i,
    input  logic          we_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rd_data_o
);

    localparam int unsigned N = 1 << LOG2_N;

    logic [DW-1:0]     buf_q [N];
    logic [LOG2_N-1:0] wr_ptr_q, wr_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (clr_i) begin
            wr_ptr_d = '0;
        end else if (we_i) begin
            // Power-of-two depth: the pointer wraps N-1 -> 0 on its own.
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetG) begin
        if (!resetG) begin
            wr_ptr_q <= '0;
            for (int i = 0; i < N; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            if (clr_i) begin
                for (int i = 0; i < N; i++) begin
                    buf_q[i] <= '0;
                end
            end else if (we_i) begin
                buf_q[wr_ptr_q] <= wdata_i;
            end
        end
    end

    assign rd_data_o = buf_q[wr_ptr_q];

endmodule

// File: rtl/meas_filter.sv
// Moving-average filter with hysteretic presence flag for ranging samples.
// Define MEAS_FILTER_TIMEOUT_EN to enable the no-sample timeout on fault_o.
module meas_filter
    import meas_filter_pkg::*;
#(
    parameter int unsigned        DW          = DW_DEF,
    parameter int unsigned        LOG2_N      = LOG2_N_DEF,
    parameter logic [DW-1:0]      TH_NEAR     = DW'(TH_NEAR_DEF),
    parameter logic [DW-1:0]      TH_FAR      = DW'(TH_FAR_DEF),
    parameter logic [TMO_W-1:0]   TIMEOUT_CYC = TMO_W'(TIMEOUT_DEF)
) (
    input  logic              clk,
    input  logic              resetG,
    input  logic [DW-1:0]     data_i,
    input  logic              done_i,
    input  logic              flush_i,
    output logic [DW-1:0]     avg_o,
    output logic              avg_stb_o,
    output logic              present_o,
    output logic [LOG2_N:0]   fill_o,
    output logic              fault_o
);

    localparam int unsigned N  = 1 << LOG2_N;
    localparam int unsigned SW = DW + LOG2_N;
    localparam logic [LOG2_N:0] FillFull = (LOG2_N + 1)'(N);
    localparam logic [LOG2_N:0] FillLast = FillFull - 1'b1;

    logic              done_q;
    logic              edge_det;
    logic [DW-1:0]     ring_rd;
    logic              ring_we;

    logic [DW-1:0]     samp_q, samp_d;
    logic [DW-1:0]     old_q, old_d;
    logic              samp_vld_q, samp_vld_d;
    logic [SW-1:0]     sum_q, sum_d;
    logic              sum_vld_q, sum_vld_d;
    logic [LOG2_N:0]   fill_q, fill_d;
    logic [DW-1:0]     avg_q, avg_d;
    logic              avg_stb_q, avg_stb_d;
    logic              present_q, present_d;
    meas_state_e       state_q, state_d;

    assign edge_det = done_i & ~done_q;
    assign ring_we  = samp_vld_q & ~flush_i;

    meas_filter_ring #(
        .DW     (DW),
        .LOG2_N (LOG2_N)
    ) u_ring (
        .clk       (clk),
        .resetG    (resetG),
        .clr_i     (flush_i),
        .we_i      (ring_we),
        .wdata_i   (samp_q),
        .rd_data_o (ring_rd)
    );

    // Stage 1: capture the new sample and the entry it will evict.
    always_comb begin
        samp_d     = samp_q;
        old_d      = old_q;
        samp_vld_d = 1'b0;
        if (edge_det && !flush_i) begin
            samp_d     = data_i;
            old_d      = ring_rd;
            samp_vld_d = 1'b1;
        end
    end

    // Stage 2: running sum and fill count.
    always_comb begin
        sum_d     = sum_q;
        fill_d    = fill_q;
        sum_vld_d = 1'b0;
        if (flush_i) begin
            sum_d  = '0;
            fill_d = '0;
        end else if (samp_vld_q) begin
            sum_d     = sum_q + SW'(samp_q) - SW'(old_q);
            sum_vld_d = 1'b1;
            if (fill_q != FillFull) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFill: begin
                if (!flush_i && samp_vld_q && fill_q == FillLast) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (flush_i) begin
                    state_d = StFill;
                end
            end
            default: state_d = StFill;
        endcase
    end

    // Stage 3: publish the average; strobe only once the window is full.
    always_comb begin
        avg_d     = avg_q;
        avg_stb_d = 1'b0;
        if (flush_i) begin
            avg_d = '0;
        end else if (sum_vld_q) begin
            avg_d     = sum_q[SW-1:LOG2_N];
            avg_stb_d = (state_q == StRun);
        end
    end

    always_comb begin
        present_d = present_q;
        if (flush_i) begin
            present_d = 1'b0;
        end else if (avg_stb_q) begin
            if (avg_q <= TH_NEAR) begin
                present_d = 1'b1;
            end else if (avg_q >= TH_FAR) begin
                present_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetG) begin
        if (!resetG) begin
            done_q     <= 1'b0;
            samp_q     <= '0;
            old_q      <= '0;
            samp_vld_q <= 1'b0;
            sum_q      <= '0;
            sum_vld_q  <= 1'b0;
            fill_q     <= '0;
            avg_q      <= '0;
            avg_stb_q  <= 1'b0;
            present_q  <= 1'b0;
            state_q    <= StFill;
        end else begin
            done_q     <= done_i;
            samp_q     <= samp_d;
            old_q      <= old_d;
            samp_vld_q <= samp_vld_d;
            sum_q      <= sum_d;
            sum_vld_q  <= sum_vld_d;
            fill_q     <= fill_d;
            avg_q      <= avg_d;
            avg_stb_q  <= avg_stb_d;
            present_q  <= present_d;
            state_q    <= state_d;
        end
    end

`ifdef MEAS_FILTER_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Saturating at the threshold keeps fault_o asserted until the next edge or flush.
    always_comb begin
        tmo_d = tmo_q;
        if (edge_det || flush_i) begin
            tmo_d = '0;
        end else if (tmo_q != TIMEOUT_CYC) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetG) begin
        if (!resetG) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    assign fault_o = (tmo_q == TIMEOUT_CYC);
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
    assign fault_o        = 1'b0;
`endif

    assign avg_o     = avg_q;
    assign avg_stb_o = avg_stb_q;
    assign present_o = present_q;
    assign fill_o    = fill_q;

endmodule

// File: tb/tb_meas_filter.sv
// Directed bench for meas_filter: averaging, hysteresis, flush, edge detect, reset, timeout.
module tb_meas_filter;

    logic        clk;
    logic        resetG;
    logic [15:0] data_i;
    logic        done_i;
    logic        flush_i;
    logic [15:0] avg_o;
    logic        avg_stb_o;
    logic        present_o;
    logic [3:0]  fill_o;
    logic        fault_o;

    int n_vec = 0;
    int n_mis = 0;

    logic [15:0] t3_avg [16] = '{16'd237, 16'd275, 16'd312, 16'd350, 16'd387, 16'd425,
                                 16'd462, 16'd500, 16'd525, 16'd550, 16'd575, 16'd600,
                                 16'd625, 16'd650, 16'd675, 16'd700};
    logic [15:0] t4_avg [8]  = '{16'd8804, 16'd16908, 16'd25013, 16'd33117, 16'd41221,
                                 16'd49326, 16'd57430, 16'd65535};
    logic [15:0] t5_val [11] = '{16'd800, 16'd800, 16'd800, 16'd800, 16'd800, 16'd800,
                                 16'd800, 16'd0, 16'd0, 16'd0, 16'd0};
    logic [15:0] t5_avg [11] = '{16'd200, 16'd300, 16'd400, 16'd500, 16'd600, 16'd700,
                                 16'd800, 16'd700, 16'd600, 16'd500, 16'd400};
    logic        t5_stb [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    meas_filter #(
        .TIMEOUT_CYC (24'd1000)
    ) dut (
        .clk       (clk),
        .resetG    (resetG),
        .data_i    (data_i),
        .done_i    (done_i),
        .flush_i   (flush_i),
        .avg_o     (avg_o),
        .avg_stb_o (avg_stb_o),
        .present_o (present_o),
        .fill_o    (fill_o),
        .fault_o   (fault_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One sample, then check the average/strobe two edges after capture and presence after.
    task automatic send_chk(input string tag, input logic [15:0] v, input logic [15:0] e_avg,
                            input logic e_stb, input logic [3:0] e_fill, input logic e_pres,
                            input int gap);
        done_i = 1'b1;
        data_i = v;
        step();
        done_i = 1'b0;
        step();
        step();
        chk({tag, ".avg"}, 32'(avg_o), 32'(e_avg));
        chk({tag, ".stb"}, 32'(avg_stb_o), 32'(e_stb));
        chk({tag, ".fill"}, 32'(fill_o), 32'(e_fill));
        step();
        chk({tag, ".stb_pulse"}, 32'(avg_stb_o), 32'd0);
        chk({tag, ".present"}, 32'(present_o), 32'(e_pres));
        repeat (gap) step();
    endtask

    initial begin
        resetG  = 1'b0;
        data_i  = '0;
        done_i  = 1'b0;
        flush_i = 1'b0;
        step();
        step();
        chk("rst.avg", 32'(avg_o), 32'd0);
        chk("rst.stb", 32'(avg_stb_o), 32'd0);
        chk("rst.present", 32'(present_o), 32'd0);
        chk("rst.fill", 32'(fill_o), 32'd0);
        chk("rst.fault", 32'(fault_o), 32'd0);
        resetG = 1'b1;
        step();
        step();

        // 1: fill window with 800, strobe only on the 8th sample
        for (int k = 1; k <= 8; k++) begin
            send_chk($sformatf("t1[%0d]", k), 16'd800, 16'(100 * k), (k == 8), 4'(k), 1'b0, 46);
        end

        // 2: 200s pull the average down; presence sets at 350
        for (int k = 1; k <= 8; k++) begin
            send_chk($sformatf("t2[%0d]", k), 16'd200, 16'(800 - 75 * k), 1'b1, 4'd8,
                     (k >= 6), 4);
        end

        // 3: 500s hold presence, then 700s clear it once avg reaches 600
        for (int k = 0; k < 16; k++) begin
            send_chk($sformatf("t3[%0d]", k), (k < 8) ? 16'd500 : 16'd700, t3_avg[k], 1'b1,
                     4'd8, (k < 11), 4);
        end

        // 4: full-scale samples, then flush coincident with an edge
        for (int k = 0; k < 8; k++) begin
            send_chk($sformatf("t4[%0d]", k), 16'hFFFF, t4_avg[k], 1'b1, 4'd8, 1'b0, 4);
        end
        done_i  = 1'b1;
        data_i  = 16'd1234;
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        done_i  = 1'b0;
        step();
        step();
        chk("t4.flush.fill", 32'(fill_o), 32'd0);
        chk("t4.flush.avg", 32'(avg_o), 32'd0);
        chk("t4.flush.stb", 32'(avg_stb_o), 32'd0);
        step();
        chk("t4.flush.stb2", 32'(avg_stb_o), 32'd0);
        chk("t4.flush.present", 32'(present_o), 32'd0);

        // 5: held-high done is one sample; then edges two cycles apart
        done_i = 1'b1;
        data_i = 16'd800;
        step();
        data_i = 16'h5555;
        repeat (99) step();
        done_i = 1'b0;
        step();
        step();
        chk("t5.held.fill", 32'(fill_o), 32'd1);
        chk("t5.held.avg", 32'(avg_o), 32'd100);
        for (int i = 0; i < 11; i++) begin
            done_i = 1'b1;
            data_i = t5_val[i];
            step();
            if (i > 0) begin
                chk($sformatf("t5[%0d].stb", i - 1), 32'(avg_stb_o), 32'(t5_stb[i - 1]));
                chk($sformatf("t5[%0d].avg", i - 1), 32'(avg_o), 32'(t5_avg[i - 1]));
            end
            done_i = 1'b0;
            step();
            chk($sformatf("t5[%0d].gap", i), 32'(avg_stb_o), 32'd0);
        end
        step();
        chk("t5[10].stb", 32'(avg_stb_o), 32'(t5_stb[10]));
        chk("t5[10].avg", 32'(avg_o), 32'(t5_avg[10]));
        step();
        step();
        chk("t5.present", 32'(present_o), 32'd1);
        chk("t5.fill", 32'(fill_o), 32'd8);

        // 6: no-sample timeout
`ifdef MEAS_FILTER_TIMEOUT_EN
        done_i = 1'b1;
        data_i = 16'd0;
        step();
        done_i = 1'b0;
        repeat (999) step();
        chk("t6.before", 32'(fault_o), 32'd0);
        step();
        chk("t6.at", 32'(fault_o), 32'd1);
        step();
        chk("t6.hold", 32'(fault_o), 32'd1);
        done_i = 1'b1;
        step();
        chk("t6.clear", 32'(fault_o), 32'd0);
        done_i = 1'b0;
        repeat (4) step();
`else
        repeat (1100) step();
        chk("t6.nofault", 32'(fault_o), 32'd0);
`endif

        // Reset in the middle of a sample's pipeline
        done_i = 1'b1;
        data_i = 16'd900;
        step();
        done_i = 1'b0;
        step();
        resetG = 1'b0;
        #1;
        chk("rst2.avg", 32'(avg_o), 32'd0);
        chk("rst2.fill", 32'(fill_o), 32'd0);
        chk("rst2.present", 32'(present_o), 32'd0);
        step();
        resetG = 1'b1;
        step();
        step();
        step();
        chk("rst2.stb", 32'(avg_stb_o), 32'd0);
        chk("rst2.avg2", 32'(avg_o), 32'd0);
        send_chk("rst2.first", 16'd800, 16'd100, 1'b0, 4'd1, 1'b0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
